dcache_controller: RTL and testbench
====================================

Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache.
- Sits between the CPU MEM stage and the 256-bit line-based Data_Memory.
- Serves 32-bit word accesses from the CPU; on a miss, stalls the pipeline and runs line-sized transactions to memory using its enable/write/ack handshake.

Parameters:
- LINES, 32, number of cache lines; power of two, 2..512.
- INDEX_BITS, 5, log2(LINES).
- TAG_BITS, 22, equals 32-5-INDEX_BITS.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-low reset.
- cpu_req_i  in  1  access request.
- cpu_we_i  in  1  1 = store, 0 = load.
- cpu_addr_i  in  32  byte address; bits [1:0] are ignored (word aligned).
- cpu_wdata_i  in  32  store data.
- cpu_rdata_o  out  32  load data.
- cpu_stall_o  out  1  request not yet complete.
- mem_enable_o  out  1  memory transaction request.
- mem_write_o  out  1  1 = write-back, 0 = line fill.
- mem_addr_o  out  32  line address; bits [4:0] are always 0.
- mem_data_o  out  256  write-back line.
- mem_ack_i  in  1  transaction done; high for one cycle.
- mem_data_i  in  256  fill line; valid in the cycle after mem_ack_i.

Behaviour:
- Reset (async, rst_i=0):
  - state=IDLE; all valid and dirty bits cleared.
  - mem_enable_o=0, mem_write_o=0, mem_addr_o=0, cpu_stall_o=0, cpu_rdata_o=0.
- Address split: offset=addr[4:2] (word within line), index=addr[4+INDEX_BITS:5], tag=addr[31:5+INDEX_BITS].
- hit = cpu_req_i & valid[index] & (tag_array[index]==tag).
- cpu_stall_o = cpu_req_i & ~(state==IDLE & hit). It is combinational.
- Read hit: cpu_rdata_o is the selected word, combinational, in the same cycle. Zero-cycle stall.
- Write hit: the selected word is updated at the clock edge and dirty[index] is set.
- While stalled, the CPU holds cpu_req_i, cpu_we_i, cpu_addr_i and cpu_wdata_i stable.
- State machine transitions:
  - IDLE:
    - req & miss & line dirty -> WRITEBACK. Drive mem_enable_o=1, mem_write_o=1, mem_addr_o={old tag,index,5'b0}, mem_data_o=line.
    - req & miss & line clean or invalid -> ALLOCATE. Drive mem_enable_o=1, mem_write_o=0, mem_addr_o={addr[31:5],5'b0}.
  - WRITEBACK: on mem_ack_i -> ALLOCATE. mem_enable_o stays 1, mem_write_o=0, mem_addr_o switches to the fill address at that edge (back-to-back transaction).
  - ALLOCATE: on mem_ack_i -> FILL; mem_enable_o cleared at that edge.
  - FILL:
    - Line <- mem_data_i, tag written, valid=1, dirty=0.
    - Next state IDLE; the held request then hits.
- mem_enable_o, mem_write_o, mem_addr_o and mem_data_o are registered and stay stable until mem_ack_i.
- mem_enable_o is never high in the cycle after the final ack of a miss.
- Latency with memory ack at the 9th cycle of enable:
  - Clean miss: stall for 11 cycles (T0..T10); completes at T11.
  - Dirty miss: stall for 20 cycles; completes at T20.
- mem_ack_i outside WRITEBACK/ALLOCATE is ignored.
- cpu_req_i=0 in IDLE: no state change, and arrays are not written.
- Reset mid-miss: transaction abandoned, the cache is left empty, and memory contents are undefined only for the aborted line.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- When defined:
  - Adds 32-bit outputs hit_count_o and miss_count_o.
  - Both reset to 0 and saturate at 0xFFFFFFFF.
  - hit_count_o increments on each IDLE cycle with req & hit.
  - miss_count_o increments on each IDLE->WRITEBACK/ALLOCATE transition. The completing re-hit after a fill is not counted as a hit.
- When undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Load 0x00000040 after reset -> miss: mem_enable_o=1 with mem_write_o=0 and mem_addr_o=0x40. cpu_stall_o high for 11 cycles. cpu_rdata_o equals word 0 of the preloaded line.
- Store 0xDEADBEEF to 0x44, then load 0x44 -> both hit with zero stall; the load returns 0xDEADBEEF and there is no memory traffic.
- Load 0x00000440 (same index as 0x44 when LINES=32, different tag) -> write-back to mem_addr_o=0x40 with the 0xDEADBEEF word, then fill from 0x440. 20 stall cycles; memory at 0x40 word 1 = 0xDEADBEEF.
- Assert rst_i=0 during the ALLOCATE wait -> mem_enable_o=0 immediately. After release, a load of the same address misses again.
- Monitor: mem_enable_o never drops before mem_ack_i, and mem_addr_o/mem_data_o stay constant from enable to ack.
- With DCACHE_STATS_EN: the sequence miss, hit, hit, miss -> hit_count_o=2, miss_count_o=2.

Source files
------------

// File: rtl/dcache_controller_if.sv
// ---------------------------------------------------------------------------
// dcache_controller_if
//   Groups the CPU-side request/response signals and the line-based memory
//   handshake of the L1 data cache into one bundle.
//
//   CPU side : cpu_req_i, cpu_we_i, cpu_addr_i[31:0], cpu_wdata_i[31:0]  (to cache)
//              cpu_rdata_o[31:0], cpu_stall_o                           (from cache)
//   Mem side : mem_enable_o, mem_write_o, mem_addr_o[31:0],
//              mem_data_o[255:0]                                        (from cache)
//              mem_ack_i, mem_data_i[255:0]                             (to cache)
//
//   modport slave  : the cache controller itself
//   modport master : the environment (CPU pipeline + Data_Memory)
// ---------------------------------------------------------------------------
interface dcache_controller_if;
  logic         cpu_req_i;
  logic         cpu_we_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_wdata_i;
  logic [31:0]  cpu_rdata_o;
  logic         cpu_stall_o;

  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_ack_i;
  logic [255:0] mem_data_i;

  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, mem_ack_i, mem_data_i,
    output cpu_rdata_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );

  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, mem_ack_i, mem_data_i,
    input  cpu_rdata_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/dcache_controller.sv
// ---------------------------------------------------------------------------
// dcache_controller
//   Direct-mapped, write-back, write-allocate L1 data cache between the CPU
//   MEM stage (32-bit words) and a 256-bit line-based data memory.
//
//   Ports:
//     clk_i        clock
//     rst_i        asynchronous active-low reset
//     bus          dcache_controller_if.slave (CPU request/response and
//                  memory enable/write/ack handshake)
//     hit_count_o  32-bit saturating hit counter   (DCACHE_STATS_EN only)
//     miss_count_o 32-bit saturating miss counter  (DCACHE_STATS_EN only)
//
//   Optional feature macro: DCACHE_STATS_EN adds the hit/miss counters.
//   Without it the counters and their ports are absent.
//
//   Hits complete combinationally in the request cycle. A miss runs an
//   optional write-back of the dirty victim followed by a line fill; the
//   memory outputs are registered and held until mem_ack_i.
// ---------------------------------------------------------------------------
module dcache_controller #(
  parameter int LINES      = 32,
  parameter int INDEX_BITS = 5,
  parameter int TAG_BITS   = 22
) (
  input  logic              clk_i,
  input  logic              rst_i,
  dcache_controller_if.slave bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_count_o,
  output logic [31:0]       miss_count_o
`endif
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WRITEBACK = 2'd1;
  localparam logic [1:0] ALLOCATE  = 2'd2;
  localparam logic [1:0] FILL      = 2'd3;

  logic [1:0]          state_q;

  // Line storage. Data and tags carry no reset; valid/dirty gate their use.
  logic [255:0]        data_q  [LINES];
  logic [TAG_BITS-1:0] tag_q   [LINES];
  logic [LINES-1:0]    valid_q;
  logic [LINES-1:0]    dirty_q;

  logic [2:0]            offset;
  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   tag;
  logic [255:0]          line_rd;
  logic [255:0]          line_wr;
  logic [TAG_BITS-1:0]   tag_rd;
  logic                  idle;
  logic                  hit;
  logic                  miss;
  logic                  write_hit;
  logic                  victim_dirty;
  logic [31:0]           fill_addr;
  logic                  addr_unused;

  assign offset       = bus.cpu_addr_i[4:2];
  assign index        = bus.cpu_addr_i[4+INDEX_BITS:5];
  assign tag          = bus.cpu_addr_i[31:5+INDEX_BITS];
  assign addr_unused  = ^bus.cpu_addr_i[1:0];

  assign line_rd      = data_q[index];
  assign tag_rd       = tag_q[index];
  assign idle         = (state_q == IDLE);
  assign hit          = bus.cpu_req_i & valid_q[index] & (tag_rd == tag);
  assign miss         = bus.cpu_req_i & ~hit;
  assign write_hit    = idle & hit & bus.cpu_we_i;
  assign victim_dirty = valid_q[index] & dirty_q[index];
  assign fill_addr    = {bus.cpu_addr_i[31:5], 5'b0};

  // The held request re-hits in the IDLE cycle after FILL, which is where
  // it completes; no separate completion path is needed.
  assign bus.cpu_stall_o = bus.cpu_req_i & ~(idle & hit);
  assign bus.cpu_rdata_o = hit ? line_rd[{offset, 5'b0} +: 32] : 32'd0;

  always_comb begin
    line_wr = line_rd;
    line_wr[{offset, 5'b0} +: 32] = bus.cpu_wdata_i;
  end

  // Data path: line/tag writes and the write-back line capture.
  always_ff @(posedge clk_i) begin
    if (state_q == FILL) begin
      data_q[index] <= bus.mem_data_i;
      tag_q[index]  <= tag;
    end else if (write_hit) begin
      data_q[index] <= line_wr;
    end
    if (idle & miss & victim_dirty) begin
      bus.mem_data_o <= line_rd;
    end
  end

  // Control: FSM, valid/dirty bits and the registered memory request.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q          <= IDLE;
      valid_q          <= '0;
      dirty_q          <= '0;
      bus.mem_enable_o <= 1'b0;
      bus.mem_write_o  <= 1'b0;
      bus.mem_addr_o   <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (write_hit) begin
            dirty_q[index] <= 1'b1;
          end else if (miss) begin
            bus.mem_enable_o <= 1'b1;
            if (victim_dirty) begin
              bus.mem_write_o <= 1'b1;
              bus.mem_addr_o  <= {tag_rd, index, 5'b0};
              state_q         <= WRITEBACK;
            end else begin
              bus.mem_write_o <= 1'b0;
              bus.mem_addr_o  <= fill_addr;
              state_q         <= ALLOCATE;
            end
          end
        end
        WRITEBACK: begin
          // Enable stays high: the fill follows back-to-back.
          if (bus.mem_ack_i) begin
            bus.mem_write_o <= 1'b0;
            bus.mem_addr_o  <= fill_addr;
            state_q         <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          if (bus.mem_ack_i) begin
            bus.mem_enable_o <= 1'b0;
            state_q          <= FILL;
          end
        end
        FILL: begin
          // mem_data_i is valid in this cycle, one after the ack.
          valid_q[index] <= 1'b1;
          dirty_q[index] <= 1'b0;
          state_q        <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic        refill_q;
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // refill_q marks the IDLE cycle right after FILL so the completing
  // re-hit of a miss is not also counted as a hit.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      refill_q   <= 1'b0;
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else begin
      refill_q <= (state_q == FILL);
      if (idle & hit & ~refill_q) hit_cnt_q <= sat_inc(hit_cnt_q);
      if (idle & miss) miss_cnt_q <= sat_inc(miss_cnt_q);
    end
  end

  assign hit_count_o  = hit_cnt_q;
  assign miss_count_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
module tb_dcache_controller;
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  dcache_controller_if bus();

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  dcache_controller #(.LINES(32), .INDEX_BITS(5), .TAG_BITS(22)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count_o  (hit_count),
    .miss_count_o (miss_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (cache is transparent to the CPU) -----
  typedef struct { bit we; logic [31:0] rdata; int stall; } resp_t;
  typedef struct { bit wr; logic [31:0] addr; logic [255:0] data; } mtx_t;

  resp_t resp_q[$];
  mtx_t  mtx_q[$];

  logic [21:0]  tag_m [32];
  bit           valid_m [32];
  bit           dirty_m [32];
  logic [31:0]  arch [logic [31:0]];   // CPU-visible word memory
  logic [255:0] bmem [logic [31:0]];   // backing line memory
  int exp_hits = 0;
  int exp_miss = 0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  function automatic logic [31:0] arch_word(input logic [31:0] a);
    if (arch.exists(a)) return arch[a];
    return init_word(a);
  endfunction

  function automatic logic [255:0] arch_line(input logic [31:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = arch_word(la + 32'(w * 4));
    return l;
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] la);
    logic [255:0] l;
    if (bmem.exists(la)) return bmem[la];
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = init_word(la + 32'(w * 4));
    return l;
  endfunction

  // Issue one CPU access, predict its outcome, wait for completion.
  task automatic do_req(input logic [31:0] addr, input bit we, input logic [31:0] wd);
    logic [31:0] a;
    logic [4:0]  idx;
    logic [21:0] tg;
    int          stall;
    int          n;
    a   = {addr[31:2], 2'b00};
    idx = a[9:5];
    tg  = a[31:10];
    if (valid_m[idx] && tag_m[idx] == tg) begin
      stall = 0;
      exp_hits++;
    end else begin
      exp_miss++;
      if (valid_m[idx] && dirty_m[idx]) begin
        mtx_q.push_back('{1'b1, {tag_m[idx], idx, 5'b0}, arch_line({tag_m[idx], idx, 5'b0})});
        stall = 20;
      end else begin
        stall = 11;
      end
      mtx_q.push_back('{1'b0, {a[31:5], 5'b0}, 256'd0});
      valid_m[idx] = 1'b1;
      tag_m[idx]   = tg;
      dirty_m[idx] = 1'b0;
    end
    if (we) begin
      arch[a]      = wd;
      dirty_m[idx] = 1'b1;
    end
    resp_q.push_back('{we, arch_word(a), stall});

    bus.cpu_req_i   = 1'b1;
    bus.cpu_we_i    = we;
    bus.cpu_addr_i  = addr;
    bus.cpu_wdata_i = wd;
    n = 0;
    @(negedge clk_i);
    while (bus.cpu_stall_o && n < 60) begin
      n++;
      @(negedge clk_i);
    end
    if (n >= 60) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: addr %0h still stalled after %0d cycles, required completion", addr, n);
    end
    @(posedge clk_i);
    #1;
    bus.cpu_req_i = 1'b0;
  endtask

  // ---------------- response monitor --------------------------------------
  int    stall_cnt = 0;
  resp_t mon_r;
  always @(negedge clk_i) begin
    if (!rst_i || !bus.cpu_req_i) begin
      stall_cnt = 0;
    end else if (bus.cpu_stall_o) begin
      stall_cnt++;
    end else begin
      if (resp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_completion: addr %0h completed, required no pending request", bus.cpu_addr_i);
      end else begin
        mon_r = resp_q.pop_front();
        chk("stall_cycles", 256'(stall_cnt), 256'(mon_r.stall));
        if (!mon_r.we) chk("load_data", 256'(bus.cpu_rdata_o), 256'(mon_r.rdata));
      end
      stall_cnt = 0;
    end
  end

  // ---------------- memory model: acks on the 9th cycle of enable ---------
  int           en_cnt = 0;
  int           txn_cnt = 0;
  bit           pending_fill = 0;
  bit           stable = 1;
  logic [255:0] fill_line;
  logic [31:0]  st_addr;
  logic [255:0] st_data;
  logic         st_wr;
  mtx_t         mm;

  initial begin
    bus.mem_ack_i  = 1'b0;
    bus.mem_data_i = '0;
    forever begin
      @(posedge clk_i);
      #1;
      if (pending_fill) begin
        bus.mem_data_i = fill_line;
        pending_fill   = 0;
        chk("enable_after_final_ack", 256'(bus.mem_enable_o), 256'd0);
      end else begin
        for (int w = 0; w < 8; w++) bus.mem_data_i[w*32 +: 32] = $urandom;
      end
      bus.mem_ack_i = 1'b0;
      if (!rst_i) begin
        en_cnt = 0;
      end else if (bus.mem_enable_o) begin
        if (en_cnt == 0) begin
          st_addr = bus.mem_addr_o;
          st_data = bus.mem_data_o;
          st_wr   = bus.mem_write_o;
          stable  = 1;
          txn_cnt++;
        end else if (st_addr !== bus.mem_addr_o || st_data !== bus.mem_data_o ||
                     st_wr !== bus.mem_write_o) begin
          stable = 0;
        end
        en_cnt++;
        if (en_cnt == 9) begin
          bus.mem_ack_i = 1'b1;
          en_cnt        = 0;
          chk("mem_outputs_stable", 256'(stable), 256'd1);
          if (mtx_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_mem_txn: addr %0h write %0b, required none", bus.mem_addr_o, bus.mem_write_o);
          end else begin
            mm = mtx_q.pop_front();
            chk("mem_write", 256'(bus.mem_write_o), 256'(mm.wr));
            chk("mem_addr", 256'(bus.mem_addr_o), 256'(mm.addr));
            if (mm.wr) chk("wb_data", bus.mem_data_o, mm.data);
          end
          if (bus.mem_write_o) begin
            bmem[{bus.mem_addr_o[31:5], 5'b0}] = bus.mem_data_o;
          end else begin
            fill_line    = mem_line({bus.mem_addr_o[31:5], 5'b0});
            pending_fill = 1;
          end
        end
      end else begin
        chk("enable_held_until_ack", 256'(en_cnt), 256'd0);
        en_cnt = 0;
        // Stray acks while no transaction is open must be ignored.
        if ($urandom_range(0, 7) == 0) bus.mem_ack_i = 1'b1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------------------------------------
  initial begin
    int          t0;
    int          n;
    logic [31:0] ra;
    bus.cpu_req_i   = 1'b0;
    bus.cpu_we_i    = 1'b0;
    bus.cpu_addr_i  = 32'd0;
    bus.cpu_wdata_i = 32'd0;
    for (int i = 0; i < 32; i++) begin
      valid_m[i] = 0;
      dirty_m[i] = 0;
      tag_m[i]   = '0;
    end

    rst_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_mem_enable", 256'(bus.mem_enable_o), 256'd0);
    chk("reset_mem_write", 256'(bus.mem_write_o), 256'd0);
    chk("reset_mem_addr", 256'(bus.mem_addr_o), 256'd0);
    chk("reset_cpu_stall", 256'(bus.cpu_stall_o), 256'd0);
    chk("reset_cpu_rdata", 256'(bus.cpu_rdata_o), 256'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Clean miss, two hits, then a dirty conflict miss on the same index.
    do_req(32'h0000_0040, 1'b0, 32'd0);
    t0 = txn_cnt;
    do_req(32'h0000_0044, 1'b1, 32'hDEAD_BEEF);
    do_req(32'h0000_0044, 1'b0, 32'd0);
    chk("no_traffic_on_hits", 256'(txn_cnt), 256'(t0));
    do_req(32'h0000_0440, 1'b0, 32'd0);
    chk("wb_word1_at_0x40", 256'(mem_line(32'h40)), 256'(arch_line(32'h40)));
    chk("wb_deadbeef", 256'(mem_line(32'h40) >> 32) & 256'hFFFF_FFFF, 256'hDEAD_BEEF);
`ifdef DCACHE_STATS_EN
    chk("stats_hits", 256'(hit_count), 256'd2);
    chk("stats_misses", 256'(miss_count), 256'd2);
`endif

    // Reset while waiting on a line fill.
    bus.cpu_req_i  = 1'b1;
    bus.cpu_we_i   = 1'b0;
    bus.cpu_addr_i = 32'h0000_0880;
    n = 0;
    while (!bus.mem_enable_o && n < 5) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    repeat (3) @(posedge clk_i);
    #3;
    chk("enable_during_allocate", 256'(bus.mem_enable_o), 256'd1);
    rst_i = 1'b0;
    #1;
    chk("enable_cleared_by_reset", 256'(bus.mem_enable_o), 256'd0);
    chk("write_cleared_by_reset", 256'(bus.mem_write_o), 256'd0);
    bus.cpu_req_i = 1'b0;
    for (int i = 0; i < 32; i++) begin
      valid_m[i] = 0;
      dirty_m[i] = 0;
    end
    exp_hits = 0;
    exp_miss = 0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    do_req(32'h0000_0880, 1'b0, 32'd0);
    do_req(32'h0000_0440, 1'b0, 32'd0);

    // Randomised traffic over a small address pool to force conflicts.
    for (int i = 0; i < 300; i++) begin
      ra = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 5) |
           (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) ra[31] = 1'b1;
      do_req(ra, 1'($urandom_range(0, 1)), $urandom);
      if ($urandom_range(0, 3) == 0) begin
        bus.cpu_we_i    = 1'b1;
        bus.cpu_addr_i  = $urandom;
        bus.cpu_wdata_i = $urandom;
        repeat ($urandom_range(1, 3)) @(posedge clk_i);
        #1;
      end
    end

    repeat (3) @(posedge clk_i);
    #1;
    chk("resp_queue_drained", 256'(resp_q.size()), 256'd0);
    chk("mem_queue_drained", 256'(mtx_q.size()), 256'd0);
`ifdef DCACHE_STATS_EN
    chk("stats_hits_final", 256'(hit_count), 256'(exp_hits));
    chk("stats_misses_final", 256'(miss_count), 256'(exp_miss));
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
